// File: rtl/instruction_fill_l1.sv
// Line-fill engine for the L1 instruction store: it requests one aligned line from the next level and writes each returned word into the store.
// Optional macro INSTR_FILL_PARITY_EN adds even-parity checking on returned words (mem_parity in, fill_err out).
module instruction_fill_l1 #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mode,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
`ifdef INSTR_FILL_PARITY_EN
    input  logic              mem_parity,
    output logic              fill_err,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);
    localparam logic [CW-1:0]     LAST_IDX  = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CW-1:0]       count_q, count_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                parity_ok;

`ifdef INSTR_FILL_PARITY_EN
    logic                err_q, err_d;
    assign parity_ok = ((^mem_data) == mem_parity);
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        busy_d     = busy_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
`ifdef INSTR_FILL_PARITY_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d    = REQ;
                    base_d     = fill_addr & LINE_MASK;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fill_addr & LINE_MASK;
`ifdef INSTR_FILL_PARITY_EN
                    err_d      = 1'b0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d    = RECV;
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                end
            end
            RECV: begin
                // A word is registered here and presented to the store one cycle later.
                if (mem_valid) begin
                    wr_en_d   = parity_ok;
                    wr_addr_d = base_q + ADDR_W'(count_q);
                    wr_data_d = mem_data;
                    count_d   = count_q + 1'b1;
`ifdef INSTR_FILL_PARITY_EN
                    if (!parity_ok) err_d = 1'b1;
`endif
                    if (count_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
`ifdef INSTR_FILL_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
`ifdef INSTR_FILL_PARITY_EN
            err_q      <= err_d;
`endif
        end
    end

    assign fill_busy = busy_q;
    assign mode      = busy_q;
    assign fill_done = done_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
`ifdef INSTR_FILL_PARITY_EN
    assign fill_err  = err_q;
`endif

endmodule

// File: tb/tb_instruction_fill_l1.sv
// Scoreboard testbench for instruction_fill_l1: expected store writes are queued as words are returned and matched as the DUT writes them.
module tb_instruction_fill_l1;

    logic        clk = 1'b0;
    logic        reset;
    logic        fill_req;
    logic [9:0]  fill_addr;
    logic        fill_busy, fill_done, mode, mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack, mem_valid;
    logic [15:0] mem_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
`ifdef INSTR_FILL_PARITY_EN
    logic        mem_parity;
    logic        fill_err;
    logic        corrupt = 1'b0;
`endif

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        logic        last;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    instruction_fill_l1 dut (
        .clk(clk), .reset(reset),
        .fill_req(fill_req), .fill_addr(fill_addr),
        .fill_busy(fill_busy), .fill_done(fill_done), .mode(mode),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data),
`ifdef INSTR_FILL_PARITY_EN
        .mem_parity(mem_parity), .fill_err(fill_err),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write monitor: every store write must match the oldest queued word, on its due cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if ({wr_addr, wr_data, fill_done} !== {e.addr, e.data, e.last} || cyc != e.due) begin
                    bad++;
                    $display("[TB] FAIL write_match: got addr=%h data=%h done=%b cyc=%0d, required addr=%h data=%h done=%b cyc=%0d",
                             wr_addr, wr_data, fill_done, cyc, e.addr, e.data, e.last, e.due);
                end
            end
        end else if (fill_done === 1'b1) begin
`ifndef INSTR_FILL_PARITY_EN
            total++;
            bad++;
            $display("[TB] FAIL done_without_write: got fill_done=1 wr_en=0, required fill_done only with a write");
`endif
        end
        if (mode !== fill_busy) begin
            total++;
            bad++;
            $display("[TB] FAIL mode_eq_busy: got mode=%b busy=%b, required equal", mode, fill_busy);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [9:0] a);
        fill_req  = 1'b1;
        fill_addr = a;
        step();
        fill_req  = 1'b0;
    endtask

    task automatic ack_after(input int waits);
        repeat (waits) step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [9:0] a, input logic last, input logic expect_write);
        mem_valid = 1'b1;
        mem_data  = d;
`ifdef INSTR_FILL_PARITY_EN
        mem_parity = (^d) ^ corrupt;
`endif
        if (expect_write) sb.push_back('{a, d, last, cyc + 1});
        step();
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fill_req  = 1'($urandom);
            fill_addr = 10'($urandom);
            mem_ack   = 1'($urandom);
            mem_valid = 1'($urandom);
            mem_data  = 16'($urandom);
`ifdef INSTR_FILL_PARITY_EN
            mem_parity = 1'($urandom);
`endif
            step();
            total++;
            if ({fill_busy, fill_done, mode, mem_req, mem_addr, wr_en, wr_addr, wr_data} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_outputs: got busy=%b done=%b mode=%b req=%b maddr=%h wen=%b waddr=%h wdata=%h, required all 0",
                         fill_busy, fill_done, mode, mem_req, mem_addr, wr_en, wr_addr, wr_data);
            end
        end
        fill_req = 1'b0; fill_addr = '0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        start_fill(10'h013);
        total++;
        if ({fill_busy, mode, mem_req, mem_addr} !== {1'b1, 1'b1, 1'b1, 10'h010}) begin
            bad++;
            $display("[TB] FAIL basic_req: got busy=%b mode=%b req=%b maddr=%h, required 1 1 1 010", fill_busy, mode, mem_req, mem_addr);
        end
        step(); step();
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_req_held: got mem_req=%b, required 1", mem_req);
        end
        ack_after(0);
        total++;
        if ({mem_req, fill_busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL basic_req_drop: got mem_req=%b busy=%b, required 0 1", mem_req, fill_busy);
        end
        for (int i = 0; i < 4; i++)
            send_word(16'hA001 + 16'(i), 10'h010 + 10'(i), i == 3, 1'b1);
        step();
        total++;
        if ({fill_busy, mode, 32'(sb.size())} !== {2'b00, 32'd0}) begin
            bad++;
            $display("[TB] FAIL basic_end: got busy=%b mode=%b pending=%0d, required 0 0 0", fill_busy, mode, sb.size());
        end
    endtask

    task automatic test_stall();
        logic [6:0] pattern;
        int         n;
        pattern = 7'b1011001;
        n = 0;
        start_fill(10'h040);
        ack_after(0);
        for (int i = 6; i >= 0; i--) begin
            if (pattern[i]) begin
                send_word(16'h5000 + 16'(n), 10'h040 + 10'(n), n == 3, 1'b1);
                n++;
            end else begin
                step();
            end
        end
        step();
        total++;
        if ({fill_busy, 32'(sb.size())} !== {1'b0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL stall_end: got busy=%b pending=%0d, required 0 0", fill_busy, sb.size());
        end
    endtask

    task automatic test_boundary();
        start_fill(10'h3FF);
        total++;
        if (mem_addr !== 10'h3FC) begin
            bad++;
            $display("[TB] FAIL boundary_base: got mem_addr=%h, required 3fc", mem_addr);
        end
        mem_valid = 1'b1; mem_data = 16'hDEAD;
`ifdef INSTR_FILL_PARITY_EN
        mem_parity = ^mem_data;
`endif
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; mem_valid = 1'b0;
        send_word(16'hB000, 10'h3FC, 1'b0, 1'b1);
        fill_req = 1'b1; fill_addr = 10'h100;
        for (int i = 1; i < 4; i++)
            send_word(16'hB000 + 16'(i), 10'h3FC + 10'(i), i == 3, 1'b1);
        fill_req = 1'b0;
        mem_valid = 1'b1; mem_data = 16'hBEEF;
        step();
        mem_valid = 1'b0;
        step();
        total++;
        if ({fill_busy, mem_req, 32'(sb.size())} !== {2'b00, 32'd0}) begin
            bad++;
            $display("[TB] FAIL boundary_ignore: got busy=%b req=%b pending=%0d, required 0 0 0", fill_busy, mem_req, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        start_fill(10'h080);
        ack_after(1);
        send_word(16'hC000, 10'h080, 1'b0, 1'b1);
        send_word(16'hC001, 10'h081, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        #1;
        total++;
        if ({fill_busy, fill_done, mode, mem_req, mem_addr, wr_en, wr_addr, wr_data} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs: got busy=%b done=%b wen=%b waddr=%h, required all 0", fill_busy, fill_done, wr_en, wr_addr);
        end
        step();
        sb.delete();
        reset = 1'b1;
        step();
        start_fill(10'h020);
        ack_after(0);
        for (int i = 0; i < 4; i++)
            send_word(16'hD000 + 16'(i), 10'h020 + 10'(i), i == 3, 1'b1);
        step();
        total++;
        if ({fill_busy, 32'(sb.size())} !== {1'b0, 32'd0}) begin
            bad++;
            $display("[TB] FAIL midreset_refill: got busy=%b pending=%0d, required 0 0", fill_busy, sb.size());
        end
    endtask

`ifdef INSTR_FILL_PARITY_EN
    task automatic test_parity();
        start_fill(10'h0C0);
        ack_after(0);
        for (int i = 0; i < 4; i++) begin
            corrupt = (i == 2);
            send_word(16'hE000 + 16'(i), 10'h0C0 + 10'(i), i == 3, i != 2);
        end
        corrupt = 1'b0;
        step();
        total++;
        if ({fill_err, 32'(sb.size())} !== {1'b1, 32'd0}) begin
            bad++;
            $display("[TB] FAIL parity_err: got fill_err=%b pending=%0d, required 1 0", fill_err, sb.size());
        end
        start_fill(10'h0D0);
        total++;
        if (fill_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL parity_clear: got fill_err=%b, required 0", fill_err);
        end
        ack_after(0);
        for (int i = 0; i < 4; i++)
            send_word(16'hF000 + 16'(i), 10'h0D0 + 10'(i), i == 3, 1'b1);
        step();
    endtask
`endif

    initial begin
        fill_req = 1'b0; fill_addr = '0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
`ifdef INSTR_FILL_PARITY_EN
        mem_parity = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_boundary();
        test_reset_mid();
`ifdef INSTR_FILL_PARITY_EN
        test_parity();
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
